// File: rtl/interrupt_sequencer_if.sv
// interrupt_sequencer_if: core-facing signals of the interrupt sequencer.
// master = sequencer side, slave = processor core side.
interface interrupt_sequencer_if;
    logic        INT;
    logic        branch_pending;
    logic        rti;
    logic [31:0] pc_in;
    logic [2:0]  ccr_in;
    logic [15:0] pop_data;
    logic        int_stall;
    logic        int_signal;
    logic [1:0]  counter;
    logic [15:0] push_data;
    logic        pop_req;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        ccr_load;
    logic [2:0]  ccr_out;
    logic        int_ack;
    modport master (
        input  INT, branch_pending, rti, pc_in, ccr_in, pop_data,
        output int_stall, int_signal, counter, push_data, pop_req,
               pc_load, pc_target, ccr_load, ccr_out, int_ack
    );
    modport slave (
        output INT, branch_pending, rti, pc_in, ccr_in, pop_data,
        input  int_stall, int_signal, counter, push_data, pop_req,
               pc_load, pc_target, ccr_load, ccr_out, int_ack
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: INT sync, pipeline drain, 3-word context push/pop and PC redirect.
// Define INT_EDGE_EN for rising-edge requests latched until accepted (default: level).
module interrupt_sequencer #(
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 3,
    parameter int          SYNC_STAGES  = 2
) (
    input logic                  clk,
    input logic                  RESET,
    interrupt_sequencer_if.master bus
);
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_PUSH, S_VECTOR, S_RESTORE} state_t;
    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_drain;
    logic [1:0]             r_step;
    logic [31:0]            r_pc;
    logic [2:0]             r_ccr;
    logic                   w_int_req, w_req, w_accept;
    logic                   w_push, w_pop, w_load, w_vec;

    assign w_int_req = r_sync[SYNC_STAGES-1];
    assign w_accept  = (r_state == S_IDLE) && !bus.rti && w_req && !bus.branch_pending;

`ifdef INT_EDGE_EN
    logic r_prev, r_pend;
    assign w_req = r_pend | (w_int_req & ~r_prev);
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= w_int_req;
            r_pend <= w_req & ~w_accept;
        end
    end
`else
    assign w_req = w_int_req;
`endif

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = bus.rti ? S_RESTORE : w_accept ? S_DRAIN : S_IDLE;
            S_DRAIN:   w_next = (r_drain == '0) ? S_PUSH : S_DRAIN;
            S_PUSH:    w_next = (r_step == 2'd2) ? S_VECTOR : S_PUSH;
            S_VECTOR:  w_next = S_IDLE;
            S_RESTORE: w_next = (r_step == 2'd3) ? S_IDLE : S_RESTORE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Restore words arrive one cycle after their pop request, so step n captures word n-1.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_sync  <= '0;
            r_drain <= '0;
            r_step  <= '0;
            r_pc    <= '0;
            r_ccr   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.INT};
            r_drain <= (r_state == S_DRAIN) ? r_drain - 1'b1 : DW'(DRAIN_CYCLES - 1);
            r_step  <= ((r_state == w_next) && (r_state == S_PUSH || r_state == S_RESTORE)) ? r_step + 2'd1 : 2'd0;
            if (w_accept) begin
                r_pc  <= bus.pc_in;
                r_ccr <= bus.ccr_in;
            end else if (r_state == S_RESTORE) begin
                if (r_step == 2'd1) r_ccr <= bus.pop_data[2:0];
                if (r_step == 2'd2) r_pc[15:0] <= bus.pop_data;
                if (r_step == 2'd3) r_pc[31:16] <= bus.pop_data;
            end
        end
    end

    assign w_push = (r_state == S_PUSH);
    assign w_pop  = (r_state == S_RESTORE) && (r_step != 2'd3);
    assign w_load = (r_state == S_RESTORE) && (r_step == 2'd3);
    assign w_vec  = (r_state == S_VECTOR);

    always_comb begin
        bus.int_stall  = (r_state != S_IDLE);
        bus.int_signal = w_push;
        bus.pop_req    = w_pop;
        bus.counter    = w_push ? r_step : w_pop ? 2'd2 - r_step : 2'd0;
        bus.push_data  = !w_push ? 16'h0 : (r_step == 2'd0) ? r_pc[31:16] :
                         (r_step == 2'd1) ? r_pc[15:0] : {13'b0, r_ccr};
        bus.pc_load    = w_vec | w_load;
        bus.ccr_load   = w_load;
        bus.int_ack    = w_vec;
        bus.pc_target  = w_vec ? INT_VECTOR : w_load ? {bus.pop_data, r_pc[15:0]} : 32'h0;
        bus.ccr_out    = w_load ? r_ccr : 3'b0;
    end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scenarios for the interrupt sequencer, one task each.
module tb_interrupt_sequencer;
    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    interrupt_sequencer_if bus();
    interrupt_sequencer dut (.clk(clk), .RESET(RESET), .bus(bus));

    int checks = 0;
    int errors = 0;
    int n_ack  = 0;
    int n_load = 0;
    logic [58:0] all_out;
    assign all_out = {bus.int_stall, bus.int_signal, bus.counter, bus.push_data, bus.pop_req,
                      bus.pc_load, bus.pc_target, bus.ccr_load, bus.ccr_out, bus.int_ack};

    always @(negedge clk) begin
        if (bus.int_ack === 1'b1) n_ack  <= n_ack + 1;
        if (bus.pc_load === 1'b1) n_load <= n_load + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stall;
        for (int i = 0; i < 20 && bus.int_stall !== 1'b1; i++) step();
        checks++;
        if (bus.int_stall !== 1'b1) begin
            errors++;
            $display("FAIL wait_stall: int_stall=%b required 1 within 20 cycles", bus.int_stall);
        end
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 30 && bus.int_stall !== 1'b0; i++) step();
        checks++;
        if (bus.int_stall !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: int_stall=%b required 0 within 30 cycles", bus.int_stall);
        end
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        bus.INT = 1'b1;
        repeat (3) step();
        checks++;
        if (all_out !== 59'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", all_out);
        end
        RESET = 1'b1;
        step();
        step();
        checks++;
        if (bus.int_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_early: int_stall=%b required 0", bus.int_stall);
        end
        step();
        checks++;
        if (bus.int_stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_latency: int_stall=%b required 1", bus.int_stall);
        end
        bus.INT = 1'b0;
        wait_idle();
    endtask

    task automatic test_push;
        logic [15:0] exp_w [3] = '{16'h0001, 16'h0A20, 16'h0005};
        bus.pc_in  = 32'h0001_0A20;
        bus.ccr_in = 3'b101;
        bus.INT    = 1'b1;
        step();
        bus.INT = 1'b0;
        wait_stall();
        bus.pc_in  = 32'hFFFF_FFFF;
        bus.ccr_in = 3'b000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.int_stall !== 1'b1 || bus.int_signal !== 1'b0 || bus.counter !== 2'd0) begin
                errors++;
                $display("FAIL drain%0d: stall=%b signal=%b counter=%0d required 1 0 0", i, bus.int_stall, bus.int_signal, bus.counter);
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.int_signal !== 1'b1 || bus.counter !== 2'(i) || bus.push_data !== exp_w[i] || bus.int_stall !== 1'b1) begin
                errors++;
                $display("FAIL push%0d: signal=%b counter=%0d data=%h required 1 %0d %h", i, bus.int_signal, bus.counter, bus.push_data, i, exp_w[i]);
            end
            step();
        end
        checks++;
        if (bus.pc_load !== 1'b1 || bus.pc_target !== 32'h0 || bus.int_ack !== 1'b1 || bus.int_signal !== 1'b0 || bus.ccr_load !== 1'b0) begin
            errors++;
            $display("FAIL vector: pc_load=%b target=%h ack=%b signal=%b ccr_load=%b required 1 0 1 0 0", bus.pc_load, bus.pc_target, bus.int_ack, bus.int_signal, bus.ccr_load);
        end
        step();
        checks++;
        if (bus.int_ack !== 1'b0 || bus.pc_load !== 1'b0 || bus.int_stall !== 1'b0) begin
            errors++;
            $display("FAIL after_vector: ack=%b pc_load=%b stall=%b required 0 0 0", bus.int_ack, bus.pc_load, bus.int_stall);
        end
    endtask

    task automatic test_restore;
        logic [15:0] words [3] = '{16'h0005, 16'h0A20, 16'h0001};
        int n0;
        n0 = n_load;
        bus.pop_data = 16'h7777;
        bus.rti = 1'b1;
        step();
        bus.rti = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.pop_req !== 1'b1 || bus.counter !== 2'(2 - i) || bus.int_stall !== 1'b1 || bus.pc_load !== 1'b0) begin
                errors++;
                $display("FAIL pop%0d: pop_req=%b counter=%0d stall=%b pc_load=%b required 1 %0d 1 0", i, bus.pop_req, bus.counter, bus.int_stall, bus.pc_load, 2 - i);
            end
            step();
            bus.pop_data = words[i];
        end
        #1;
        checks++;
        if (bus.pc_load !== 1'b1 || bus.ccr_load !== 1'b1 || bus.pc_target !== 32'h0001_0A20 || bus.ccr_out !== 3'b101 || bus.pop_req !== 1'b0 || bus.counter !== 2'd0) begin
            errors++;
            $display("FAIL restore_load: pc_load=%b ccr_load=%b target=%h ccr=%b pop=%b required 1 1 00010a20 101 0", bus.pc_load, bus.ccr_load, bus.pc_target, bus.ccr_out, bus.pop_req);
        end
        step();
        checks++;
        if (bus.pc_load !== 1'b0 || bus.ccr_load !== 1'b0 || bus.int_stall !== 1'b0 || n_load - n0 !== 1) begin
            errors++;
            $display("FAIL restore_done: pc_load=%b ccr_load=%b stall=%b loads=%0d required 0 0 0 1", bus.pc_load, bus.ccr_load, bus.int_stall, n_load - n0);
        end
    endtask

    task automatic test_branch_hold;
        bus.pc_in  = 32'hDEAD_BEEF;
        bus.ccr_in = 3'b010;
        bus.branch_pending = 1'b1;
        bus.INT = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bus.int_stall !== 1'b0) begin
                errors++;
                $display("FAIL branch_hold%0d: int_stall=%b required 0", i, bus.int_stall);
            end
        end
        bus.branch_pending = 1'b0;
        step();
        bus.INT = 1'b0;
        checks++;
        if (bus.int_stall !== 1'b1) begin
            errors++;
            $display("FAIL branch_release: int_stall=%b required 1", bus.int_stall);
        end
        repeat (3) step();
        checks++;
        if (bus.int_signal !== 1'b1 || bus.push_data !== 16'hDEAD) begin
            errors++;
            $display("FAIL branch_push_hi: signal=%b data=%h required 1 dead", bus.int_signal, bus.push_data);
        end
        repeat (2) step();
        checks++;
        if (bus.counter !== 2'd2 || bus.push_data !== 16'h0002) begin
            errors++;
            $display("FAIL branch_push_ccr: counter=%0d data=%h required 2 0002", bus.counter, bus.push_data);
        end
        step();
        checks++;
        if (bus.int_ack !== 1'b1 || bus.pc_target !== 32'h0) begin
            errors++;
            $display("FAIL branch_vector: ack=%b target=%h required 1 0", bus.int_ack, bus.pc_target);
        end
        wait_idle();
    endtask

    task automatic test_rti_priority;
        bus.pop_data = 16'h0000;
        bus.INT = 1'b1;
        step();
        step();
        bus.rti = 1'b1;
        step();
        bus.rti = 1'b0;
        checks++;
        if (bus.pop_req !== 1'b1 || bus.int_signal !== 1'b0 || bus.counter !== 2'd2) begin
            errors++;
            $display("FAIL rti_priority: pop_req=%b signal=%b counter=%0d required 1 0 2", bus.pop_req, bus.int_signal, bus.counter);
        end
        for (int i = 0; i < 12 && bus.int_signal !== 1'b1; i++) step();
        bus.INT = 1'b0;
        checks++;
        if (bus.int_signal !== 1'b1) begin
            errors++;
            $display("FAIL deferred_int: int_signal=%b required 1 after restore", bus.int_signal);
        end
        repeat (4) step();
        wait_idle();
    endtask

    task automatic test_reset_mid;
        int n0;
        bus.pc_in = 32'h1234_5678;
        bus.INT = 1'b1;
        step();
        bus.INT = 1'b0;
        wait_stall();
        repeat (4) step();
        checks++;
        if (bus.int_signal !== 1'b1 || bus.counter !== 2'd1 || bus.push_data !== 16'h5678) begin
            errors++;
            $display("FAIL mid_push: signal=%b counter=%0d data=%h required 1 1 5678", bus.int_signal, bus.counter, bus.push_data);
        end
        n0 = n_load;
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (all_out !== 59'd0) begin
            errors++;
            $display("FAIL async_reset: got %h required 0", all_out);
        end
        step();
        step();
        RESET = 1'b1;
        repeat (10) step();
        checks++;
        if (n_load !== n0 || bus.int_stall !== 1'b0) begin
            errors++;
            $display("FAIL abandon: extra pc_load=%0d stall=%b required 0 0", n_load - n0, bus.int_stall);
        end
    endtask

    task automatic test_level_hold;
        int n0;
        n0 = n_ack;
        bus.INT = 1'b1;
        repeat (50) step();
        bus.INT = 1'b0;
        repeat (4) step();
        wait_idle();
        checks++;
`ifdef INT_EDGE_EN
        if (n_ack - n0 !== 1) begin
            errors++;
            $display("FAIL edge_hold: int_ack count=%0d required 1", n_ack - n0);
        end
`else
        if (n_ack - n0 < 4) begin
            errors++;
            $display("FAIL level_hold: int_ack count=%0d required at least 4", n_ack - n0);
        end
`endif
    endtask

    initial begin
        RESET = 1'b0;
        bus.INT = 1'b0;
        bus.branch_pending = 1'b0;
        bus.rti = 1'b0;
        bus.pc_in = 32'h0;
        bus.ccr_in = 3'b0;
        bus.pop_data = 16'h0;
        test_reset();
        test_push();
        test_restore();
        test_branch_hold();
        test_rti_priority();
        test_reset_mid();
        test_level_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
